// File: rtl/dmem_pkg.sv
// Shared state encoding and requester indices for the data-memory arbiter.
// Arbitration mode is selected by ARB_FIXED_PRIO_EN in dmem_rr_pick.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam int unsigned NUM_REQ    = 2;
  localparam int unsigned REQ_ICACHE = 0;
  localparam int unsigned REQ_DCACHE = 1;

  function automatic logic [NUM_REQ-1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Requester selection: round-robin by default, fixed priority to the icache
// when ARB_FIXED_PRIO_EN is defined.
module dmem_rr_pick
  import dmem_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_owner,
  output logic [NUM_REQ-1:0] pick
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    pick = req;
    if (req[REQ_ICACHE]) pick = 2'b01;
  end
`else
  always_comb begin
    pick = req;
    // On contention the requester that did not own the memory last wins.
    if (&req) pick = last_owner ? 2'b01 : 2'b10;
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester (icache/dcache) arbiter in front of a single data memory port,
// with a sticky WAIT watchdog. ARB_FIXED_PRIO_EN selects fixed-priority picking.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            rq_rd,
  input  logic [1:0]            rq_wr,
  input  logic [ADDR_WIDTH-1:0] rq_addr0,
  input  logic [ADDR_WIDTH-1:0] rq_addr1,
  input  logic [DATA_WIDTH-1:0] rq_wdata0,
  input  logic [DATA_WIDTH-1:0] rq_wdata1,
  output logic [1:0]            rq_grant,
  output logic [1:0]            rq_done,
  output logic [DATA_WIDTH-1:0] rq_rdata,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_ready,
  input  logic                  mem_done,
  output logic                  timeout_err
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  arb_state_e            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic                  op_rd_q, op_rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  terr_q, terr_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [NUM_REQ-1:0]    req, pick;
  logic                  timeout_hit;

  assign req = rq_rd | rq_wr;

  dmem_rr_pick u_pick (
    .req        (req),
    .last_owner (last_q),
    .pick       (pick)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    op_rd_d     = op_rd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    terr_d      = terr_q;
    wd_d        = wd_q;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_ready && (|req)) begin
          owner_d = pick[REQ_DCACHE];
          // Read wins when a requester raises rd and wr together.
          op_rd_d = pick[REQ_DCACHE] ? rq_rd[REQ_DCACHE] : rq_rd[REQ_ICACHE];
          addr_d  = pick[REQ_DCACHE] ? rq_addr1 : rq_addr0;
          wdata_d = pick[REQ_DCACHE] ? rq_wdata1 : rq_wdata0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        rdata_d = mem_rd_data;
        if (mem_done) begin
          state_d = RELEASE;
        end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          timeout_hit = 1'b1;
          terr_d      = 1'b1;
          state_d     = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RELEASE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rq_grant    = (state_q != IDLE) ? owner_onehot(owner_q) : '0;
    // A watchdog expiry completes the transaction from WAIT directly.
    rq_done     = ((state_q == RELEASE) || timeout_hit) ? owner_onehot(owner_q) : '0;
    mem_rd_en   = (state_q == ISSUE) && op_rd_q;
    mem_wr_en   = (state_q == ISSUE) && !op_rd_q;
    mem_address = addr_q;
    mem_wr_data = wdata_q;
    rq_rdata    = rdata_q;
    timeout_err = terr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      op_rd_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      terr_q  <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      op_rd_q <= op_rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      terr_q  <= terr_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    rq_rd, rq_wr;
  logic [AW-1:0] rq_addr0, rq_addr1;
  logic [DW-1:0] rq_wdata0, rq_wdata1;
  logic [1:0]    rq_grant, rq_done;
  logic [DW-1:0] rq_rdata;
  logic          mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wr_data, mem_rd_data;
  logic          mem_ready, mem_done, timeout_err;

  int errors = 0;
  int checks = 0;

  // Reference model: the current transaction (owner, age in cycles since issue,
  // whether memory has completed) plus the persistent arbiter facts.
  int            m_owner;
  int            m_age;
  bit            m_rel;
  int            m_last;
  bit            m_isrd;
  bit            m_terr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .rq_rd(rq_rd), .rq_wr(rq_wr),
    .rq_addr0(rq_addr0), .rq_addr1(rq_addr1),
    .rq_wdata0(rq_wdata0), .rq_wdata1(rq_wdata1),
    .rq_grant(rq_grant), .rq_done(rq_done), .rq_rdata(rq_rdata),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_address(mem_address), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .mem_ready(mem_ready), .mem_done(mem_done),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_rel = 0; m_last = 1; m_isrd = 0; m_terr = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
  endtask

  task automatic model_step();
    logic [1:0] req;
    int w;
    if (m_owner < 0) begin
      req = rq_rd | rq_wr;
      if (mem_ready && req != 2'b00) begin
        if (req == 2'b11) begin
`ifdef ARB_FIXED_PRIO_EN
          w = 0;
`else
          w = (m_last == 0) ? 1 : 0;
`endif
        end else begin
          w = req[1] ? 1 : 0;
        end
        m_owner = w; m_age = 0; m_rel = 0;
        m_isrd  = rq_rd[w];
        m_addr  = (w == 1) ? rq_addr1 : rq_addr0;
        m_wdata = (w == 1) ? rq_wdata1 : rq_wdata0;
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (m_rel) begin
      m_last  = m_owner;
      m_owner = -1;
    end else begin
      m_rdata = mem_rd_data;
      if (mem_done) m_rel = 1;
      else if (m_age == TO) begin m_terr = 1; m_owner = -1; end
      else m_age++;
    end
  endtask

  task automatic compare();
    logic [1:0] oh;
    bit tmo, act;
    oh = 2'b00;
    if (m_owner == 0) oh = 2'b01;
    else if (m_owner == 1) oh = 2'b10;
    act = (m_owner >= 0);
    tmo = act && m_age >= 1 && !m_rel && !mem_done && m_age == TO;
    chk("grant", rq_grant, oh);
    chk("done", rq_done, (act && (m_rel || tmo)) ? oh : 2'b00);
    chk("rd_en", mem_rd_en, act && m_age == 0 && m_isrd);
    chk("wr_en", mem_wr_en, act && m_age == 0 && !m_isrd);
    chk("address", mem_address, m_addr);
    chk("wr_data", mem_wr_data, m_wdata);
    chk("rdata", rq_rdata, m_rdata);
    chk("timeout_err", timeout_err, m_terr);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    compare();
    chk("rst_grant", rq_grant, 2'b00);
    chk("rst_done", rq_done, 2'b00);
    chk("rst_rdata", rq_rdata, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_err", timeout_err, 0);
    reset = 1'b0;
  endtask

  task automatic quiet_inputs();
    rq_rd = 2'b00; rq_wr = 2'b00;
    rq_addr0 = '0; rq_addr1 = '0; rq_wdata0 = '0; rq_wdata1 = '0;
    mem_rd_data = '0; mem_ready = 1'b1; mem_done = 1'b0;
  endtask

  initial begin
    logic [1:0] exp2;
    quiet_inputs();
    do_reset();

    // Single read from icache, memory completes after 20 WAIT cycles.
    rq_rd = 2'b01; rq_addr0 = 32'h10;
    tick();
    chk("rd_issue_en", mem_rd_en, 1);
    chk("rd_issue_addr", mem_address, 32'h10);
    chk("rd_issue_grant", rq_grant, 2'b01);
    rq_rd = 2'b00;
    tick();
    chk("rd_single_pulse", mem_rd_en, 0);
    repeat (19) tick();
    mem_rd_data = 32'h1234; mem_done = 1'b1;
    tick();
    chk("rd_done", rq_done, 2'b01);
    chk("rd_rdata", rq_rdata, 32'h1234);
    mem_done = 1'b0;
    tick();
    chk("rd_after_done", rq_done, 2'b00);
    chk("rd_after_grant", rq_grant, 2'b00);

    // Single write from dcache.
    rq_wr = 2'b10; rq_addr1 = 32'h8; rq_wdata1 = 32'hCAFE;
    tick();
    chk("wr_issue_en", mem_wr_en, 1);
    chk("wr_issue_rd", mem_rd_en, 0);
    chk("wr_issue_addr", mem_address, 32'h8);
    chk("wr_issue_data", mem_wr_data, 32'hCAFE);
    rq_wr = 2'b00;
    tick(); tick();
    mem_done = 1'b1;
    tick();
    chk("wr_done", rq_done, 2'b10);
    mem_done = 1'b0;
    tick();

    // Simultaneous reads held across two transactions.
    do_reset();
    rq_rd = 2'b11; rq_addr0 = 32'hA0; rq_addr1 = 32'hB0;
    tick();
    chk("both_first_grant", rq_grant, 2'b01);
    tick();
    mem_done = 1'b1; tick();
    mem_done = 1'b0; tick();
    tick();
`ifdef ARB_FIXED_PRIO_EN
    exp2 = 2'b01;
`else
    exp2 = 2'b10;
`endif
    chk("both_second_grant", rq_grant, exp2);
    rq_rd = 2'b00;
    tick();
    mem_done = 1'b1; tick();
    mem_done = 1'b0; tick();

    // Memory never completes: watchdog expires after TO WAIT cycles.
    do_reset();
    rq_rd = 2'b01;
    tick();
    rq_rd = 2'b00;
    repeat (TO - 1) tick();
    chk("tmo_not_yet", rq_done, 2'b00);
    tick();
    chk("tmo_done_pulse", rq_done, 2'b01);
    tick();
    chk("tmo_err", timeout_err, 1);
    chk("tmo_idle_grant", rq_grant, 2'b00);
    chk("tmo_idle_done", rq_done, 2'b00);
    tick();
    chk("tmo_sticky", timeout_err, 1);

    // Reset in the middle of WAIT abandons the transaction.
    do_reset();
    rq_rd = 2'b10; mem_rd_data = 32'hDEAD;
    tick();
    rq_rd = 2'b00;
    tick(); tick();
    chk("mid_rdata_seen", rq_rdata, 32'hDEAD);
    do_reset();
    chk("mid_rst_rd_en", mem_rd_en, 0);
    tick();
    chk("mid_rst_no_done", rq_done, 2'b00);

    // Memory not ready holds off the command.
    mem_ready = 1'b0; rq_rd = 2'b01; rq_addr0 = 32'h44;
    repeat (5) begin
      tick();
      chk("notready_rd_en", mem_rd_en, 0);
    end
    mem_ready = 1'b1;
    tick();
    chk("ready_rd_en", mem_rd_en, 1);
    rq_rd = 2'b00;
    tick();
    mem_done = 1'b1; tick();
    mem_done = 1'b0; tick();

    // Random traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rq_rd = 2'($urandom);
        rq_wr = 2'($urandom);
      end
      rq_addr0 = $urandom; rq_addr1 = $urandom;
      rq_wdata0 = $urandom; rq_wdata1 = $urandom;
      mem_rd_data = $urandom;
      mem_ready = ($urandom_range(0, 7) != 0);
      mem_done = (i < 3000) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 999) == 0) do_reset();
      else tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
